// File: rtl/fft_input_loader_if.sv
// Sample stream and input-RAM write bus between the FFT input loader (master)
// and the FFT core / upstream source (slave).
interface fft_input_loader_if #(
    parameter int IDWL = 16,
    parameter int IWL  = 32,
    parameter int AWL  = 5
);
    logic            i_S_VALID;
    logic            o_S_READY;
    logic [IDWL-1:0] i_S_RE;
    logic [IDWL-1:0] i_S_IM;
    logic            i_S_LAST;
    logic [IWL-1:0]  o_A_DATA;
    logic [IWL-1:0]  o_B_DATA;
    logic [AWL-1:0]  o_A_ADDR;
    logic [AWL-1:0]  o_B_ADDR;
    logic            o_RAM_Wr;
    logic            o_START;
    logic            i_RAM_BLOCK;
    logic            o_FRAME_ERR;
    logic [15:0]     o_FRAME_CNT;

    modport master (
        input  i_S_VALID, i_S_RE, i_S_IM, i_S_LAST, i_RAM_BLOCK,
        output o_S_READY, o_A_DATA, o_B_DATA, o_A_ADDR, o_B_ADDR,
        output o_RAM_Wr, o_START, o_FRAME_ERR, o_FRAME_CNT
    );

    modport slave (
        output i_S_VALID, i_S_RE, i_S_IM, i_S_LAST, i_RAM_BLOCK,
        input  o_S_READY, o_A_DATA, o_B_DATA, o_A_ADDR, o_B_ADDR,
        input  o_RAM_Wr, o_START, o_FRAME_ERR, o_FRAME_CNT
    );
endinterface

// File: rtl/fft_input_loader.sv
// Packs complex samples into {re, im} words and writes them pairwise into the
// FFT core's dual-port input RAM, then pulses START for each complete frame.
module fft_input_loader #(
    parameter int IDWL        = 16,
    parameter int IWL         = 32,
    parameter int AWL         = 5,
    parameter int BIT_REVERSE = 0
) (
    input  logic CLK,
    input  logic RST,
    input  logic EN,
    fft_input_loader_if.master bus
);

    generate
        if (IWL != 2 * IDWL) begin : g_bad_width
            $error("fft_input_loader: IWL must equal 2*IDWL");
        end
    endgenerate

    localparam logic [AWL-1:0] N_LAST = '1;

    // LAST_WR covers the cycle in which the final pair is being written, so
    // START lands exactly one cycle after the last write strobe.
    typedef enum logic [2:0] {
        FILL,
        LAST_WR,
        LAUNCH,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t state, state_nxt;

    logic [AWL-1:0] n_q;
    logic [IWL-1:0] hold_word_p0;
    logic [AWL-1:0] hold_addr_p0;
    logic [IWL-1:0] a_data_p1;
    logic [IWL-1:0] b_data_p1;
    logic [AWL-1:0] a_addr_p1;
    logic [AWL-1:0] b_addr_p1;
    logic           vld_p1;
    logic           err_p1;
    logic [15:0]    frame_cnt;

    logic           hs;
    logic           early_last;
    logic           frame_end;
    logic [IWL-1:0] word;
    logic [AWL-1:0] addr;

    function automatic logic [AWL-1:0] map_addr(input logic [AWL-1:0] idx);
        logic [AWL-1:0] rev;
        for (int i = 0; i < AWL; i++) begin
            rev[i] = idx[AWL-1-i];
        end
        return (BIT_REVERSE != 0) ? rev : idx;
    endfunction

    assign bus.o_S_READY = RST & EN & ~bus.i_RAM_BLOCK & (state == FILL);
    assign hs            = bus.i_S_VALID & bus.o_S_READY;
    assign early_last    = bus.i_S_LAST & (n_q != N_LAST);
    assign frame_end     = hs & ~early_last & (n_q == N_LAST);
    assign word          = {bus.i_S_RE[IDWL-1:0], bus.i_S_IM[IDWL-1:0]};
    assign addr          = map_addr(n_q);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (EN) begin
            case (state)
                FILL:    if (frame_end) state_nxt = LAST_WR;
                LAST_WR: state_nxt = LAUNCH;
                LAUNCH:  state_nxt = WAIT_HI;
                WAIT_HI: if (bus.i_RAM_BLOCK) state_nxt = WAIT_LO;
                WAIT_LO: if (!bus.i_RAM_BLOCK) state_nxt = FILL;
                default: state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            n_q          <= '0;
            hold_word_p0 <= '0;
            hold_addr_p0 <= '0;
            a_data_p1    <= '0;
            b_data_p1    <= '0;
            a_addr_p1    <= '0;
            b_addr_p1    <= '0;
            vld_p1       <= 1'b0;
            err_p1       <= 1'b0;
            frame_cnt    <= '0;
        end else if (EN) begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            if (state == LAUNCH) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (hs) begin
                if (early_last) begin
                    // Abort: a half-filled pair is never written.
                    n_q          <= '0;
                    hold_word_p0 <= '0;
                    hold_addr_p0 <= '0;
                    err_p1       <= 1'b1;
                end else if (!n_q[0]) begin
                    // stage p0: even sample waits for its odd partner
                    hold_word_p0 <= word;
                    hold_addr_p0 <= addr;
                    n_q          <= n_q + AWL'(1);
                end else begin
                    // stage p1: pair presented to both RAM ports
                    a_data_p1 <= hold_word_p0;
                    a_addr_p1 <= hold_addr_p0;
                    b_data_p1 <= word;
                    b_addr_p1 <= addr;
                    vld_p1    <= 1'b1;
                    n_q       <= n_q + AWL'(1);
                end
            end
        end
    end

    assign bus.o_A_DATA    = a_data_p1;
    assign bus.o_B_DATA    = b_data_p1;
    assign bus.o_A_ADDR    = a_addr_p1;
    assign bus.o_B_ADDR    = b_addr_p1;
    assign bus.o_RAM_Wr    = vld_p1 & EN;
    assign bus.o_START     = (state == LAUNCH) & EN;
    assign bus.o_FRAME_ERR = err_p1 & EN;
    assign bus.o_FRAME_CNT = frame_cnt;

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench: two loaders (natural and bit-reversed order, AWL=3) fed the
// same 8-sample stream; writes are captured and compared against a table.
module tb_fft_input_loader;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic EN  = 1'b1;
    logic        valid = 1'b0;
    logic [15:0] re    = '0;
    logic [15:0] im    = '0;
    logic        last  = 1'b0;
    logic        block = 1'b0;

    always #5 CLK = ~CLK;

    fft_input_loader_if #(.IDWL(16), .IWL(32), .AWL(3)) bus0 ();
    fft_input_loader_if #(.IDWL(16), .IWL(32), .AWL(3)) bus1 ();

    assign bus0.i_S_VALID = valid;   assign bus1.i_S_VALID = valid;
    assign bus0.i_S_RE = re;         assign bus1.i_S_RE = re;
    assign bus0.i_S_IM = im;         assign bus1.i_S_IM = im;
    assign bus0.i_S_LAST = last;     assign bus1.i_S_LAST = last;
    assign bus0.i_RAM_BLOCK = block; assign bus1.i_RAM_BLOCK = block;

    fft_input_loader #(.IDWL(16), .IWL(32), .AWL(3), .BIT_REVERSE(0)) u0 (
        .CLK(CLK), .RST(RST), .EN(EN), .bus(bus0.master));
    fft_input_loader #(.IDWL(16), .IWL(32), .AWL(3), .BIT_REVERSE(1)) u1 (
        .CLK(CLK), .RST(RST), .EN(EN), .bus(bus1.master));

    typedef struct {
        logic [2:0]  aa;
        logic [2:0]  ba;
        logic [31:0] ad;
        logic [31:0] bd;
    } wr_t;

    typedef struct {
        logic [2:0]  aa0, ba0, aa1, ba1;
        logic [31:0] ad, bd;
    } exp_t;

    exp_t tbl [4];
    wr_t  wq0 [$];
    wr_t  wq1 [$];
    int   cyc = 0, last_wr0 = -10, starts0 = 0, starts1 = 0, errs0 = 0, gap_bad = 0;
    int   n_vec = 0, n_err = 0;

    always @(negedge CLK) begin
        cyc++;
        if (bus0.o_RAM_Wr) begin
            wq0.push_back('{bus0.o_A_ADDR, bus0.o_B_ADDR, bus0.o_A_DATA, bus0.o_B_DATA});
            last_wr0 = cyc;
        end
        if (bus1.o_RAM_Wr)
            wq1.push_back('{bus1.o_A_ADDR, bus1.o_B_ADDR, bus1.o_A_DATA, bus1.o_B_DATA});
        if (bus0.o_START) begin
            starts0++;
            if (cyc - last_wr0 != 1 || bus0.o_RAM_Wr) gap_bad++;
        end
        if (bus1.o_START) starts1++;
        if (bus0.o_FRAME_ERR) errs0++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_capture();
        wq0.delete(); wq1.delete();
        starts0 = 0; starts1 = 0; errs0 = 0; gap_bad = 0;
    endtask

    task automatic wait_accept();
        bit acc = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge CLK);
            acc = bus0.o_S_READY;
            @(posedge CLK); #1;
            if (acc) break;
        end
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: got ready=0 for 50 cycles, expected a handshake");
        end
    endtask

    task automatic send(input int cnt, input int last_at, input bit gaps, input int en_drop_at);
        for (int n = 0; n < cnt; n++) begin
            if (gaps) begin
                valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge CLK);
                #1;
            end
            valid = 1'b1; re = 16'(n); im = 16'(-n); last = (n == last_at);
            wait_accept();
            if (n == en_drop_at) begin
                valid = 1'b0; EN = 1'b0;
                repeat (3) @(posedge CLK);
                #1 EN = 1'b1;
            end
        end
        valid = 1'b0; last = 1'b0;
    endtask

    task automatic release_block();
        repeat (4) @(posedge CLK);
        #1 block = 1'b1;
        repeat (3) @(posedge CLK);
        #1 block = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic check_frame(input string tag, input int exp_cnt);
        chk({tag, "_nwr0"}, 32'(wq0.size()), 32'd4);
        chk({tag, "_nwr1"}, 32'(wq1.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < wq0.size()) begin
                chk($sformatf("%s_p%0d_aaddr_nat", tag, i), 32'(wq0[i].aa), 32'(tbl[i].aa0));
                chk($sformatf("%s_p%0d_baddr_nat", tag, i), 32'(wq0[i].ba), 32'(tbl[i].ba0));
                chk($sformatf("%s_p%0d_adata", tag, i), wq0[i].ad, tbl[i].ad);
                chk($sformatf("%s_p%0d_bdata", tag, i), wq0[i].bd, tbl[i].bd);
            end
            if (i < wq1.size()) begin
                chk($sformatf("%s_p%0d_aaddr_rev", tag, i), 32'(wq1[i].aa), 32'(tbl[i].aa1));
                chk($sformatf("%s_p%0d_baddr_rev", tag, i), 32'(wq1[i].ba), 32'(tbl[i].ba1));
                chk($sformatf("%s_p%0d_adata_rev", tag, i), wq1[i].ad, tbl[i].ad);
                chk($sformatf("%s_p%0d_bdata_rev", tag, i), wq1[i].bd, tbl[i].bd);
            end
        end
        chk({tag, "_starts0"}, 32'(starts0), 32'd1);
        chk({tag, "_starts1"}, 32'(starts1), 32'd1);
        chk({tag, "_start_gap"}, 32'(gap_bad), 32'd0);
        chk({tag, "_frame_cnt0"}, 32'(bus0.o_FRAME_CNT), 32'(exp_cnt));
        chk({tag, "_frame_cnt1"}, 32'(bus1.o_FRAME_CNT), 32'(exp_cnt));
        clear_capture();
    endtask

    initial begin
        tbl[0] = '{3'd0, 3'd1, 3'd0, 3'd4, 32'h0000_0000, 32'h0001_FFFF};
        tbl[1] = '{3'd2, 3'd3, 3'd2, 3'd6, 32'h0002_FFFE, 32'h0003_FFFD};
        tbl[2] = '{3'd4, 3'd5, 3'd1, 3'd5, 32'h0004_FFFC, 32'h0005_FFFB};
        tbl[3] = '{3'd6, 3'd7, 3'd3, 3'd7, 32'h0006_FFFA, 32'h0007_FFF9};

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ready", 32'(bus0.o_S_READY), 32'd0);
        chk("rst_wr", 32'(bus0.o_RAM_Wr), 32'd0);
        chk("rst_start", 32'(bus0.o_START), 32'd0);
        chk("rst_err", 32'(bus0.o_FRAME_ERR), 32'd0);
        chk("rst_cnt", 32'(bus0.o_FRAME_CNT), 32'd0);
        chk("rst_adata", bus0.o_A_DATA, 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("idle_ready", 32'(bus0.o_S_READY), 32'd1);

        // Back-to-back frame, then hold-off while the core owns the RAM
        send(8, 7, 1'b0, -1);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk($sformatf("blk_lo_ready%0d", i), 32'(bus0.o_S_READY), 32'd0);
        end
        @(posedge CLK); #1 block = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk($sformatf("blk_hi_ready%0d", i), 32'(bus0.o_S_READY), 32'd0);
            if (i < 19) @(posedge CLK);
        end
        @(posedge CLK); #1 block = 1'b0;
        @(negedge CLK);
        chk("blk_fall_ready", 32'(bus0.o_S_READY), 32'd0);
        @(negedge CLK);
        chk("blk_after_ready", 32'(bus0.o_S_READY), 32'd1);
        check_frame("f1", 1);

        // Early LAST on sample 4: pairs 0/1 written, sample 4 dropped
        @(posedge CLK); #1;
        send(5, 4, 1'b0, -1);
        repeat (4) @(posedge CLK);
        #1;
        chk("early_nwr", 32'(wq0.size()), 32'd2);
        chk("early_err_pulses", 32'(errs0), 32'd1);
        chk("early_starts", 32'(starts0), 32'd0);
        chk("early_cnt", 32'(bus0.o_FRAME_CNT), 32'd1);
        chk("early_ready", 32'(bus0.o_S_READY), 32'd1);
        clear_capture();
        send(8, 7, 1'b0, -1);
        release_block();
        check_frame("f2", 2);

        // Random valid gaps with EN low for 3 cycles mid-pair
        send(8, 7, 1'b1, 2);
        release_block();
        check_frame("f3", 3);

        // Reset after 5 samples
        send(5, -1, 1'b0, -1);
        RST = 1'b0;
        #2;
        chk("mid_rst_ready", 32'(bus0.o_S_READY), 32'd0);
        chk("mid_rst_wr", 32'(bus0.o_RAM_Wr), 32'd0);
        chk("mid_rst_adata", bus0.o_A_DATA, 32'd0);
        chk("mid_rst_bdata", bus0.o_B_DATA, 32'd0);
        chk("mid_rst_baddr", 32'(bus0.o_B_ADDR), 32'd0);
        chk("mid_rst_cnt", 32'(bus0.o_FRAME_CNT), 32'd0);
        @(posedge CLK); #1 RST = 1'b1;
        clear_capture();
        send(8, 7, 1'b0, -1);
        release_block();
        check_frame("f4", 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
